sigmoid_tanh: RTL and testbench



---
 rtl/act_pkg.sv | 55 +++++
 rtl/sigmoid_plan_core.sv | 64 ++++++
 rtl/sigmoid_tanh.sv | 85 ++++++++
 tb/tb_sigmoid_tanh.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/act_pkg.sv
// Shared constants and types for the PLAN sigmoid/tanh activation unit.
// Breakpoints and offsets are produced scaled to a given fraction width.
package act_pkg;

  localparam int DEF_INT  = 8;
  localparam int DEF_FRAC = 8;
  localparam int DEF_W    = DEF_INT + DEF_FRAC + 1;

  typedef logic signed [DEF_W-1:0] fix_t;

  // Right-shift amounts of the three sloped segments
  localparam int SH_R0 = 2;
  localparam int SH_R1 = 3;
  localparam int SH_R2 = 5;

  // num / 2^den_log2 scaled by 2^frac
  function automatic int fx_scale(
    input int num,
    input int den_log2,
    input int frac
  );
    return (num << frac) >> den_log2;
  endfunction

  // 1.0
  function automatic int bp_one(input int frac);
    return fx_scale(1, 0, frac);
  endfunction

  // 2.375
  function automatic int bp_mid(input int frac);
    return fx_scale(19, 3, frac);
  endfunction

  // 5.0
  function automatic int bp_sat(input int frac);
    return fx_scale(5, 0, frac);
  endfunction

  // 0.5
  function automatic int off_r0(input int frac);
    return fx_scale(1, 1, frac);
  endfunction

  // 0.625
  function automatic int off_r1(input int frac);
    return fx_scale(5, 3, frac);
  endfunction

  // 0.84375
  function automatic int off_r2(input int frac);
    return fx_scale(27, 5, frac);
  endfunction

endpackage

// File: rtl/sigmoid_plan_core.sv
// Combinational PLAN sigmoid on a non-negative magnitude.
// Macro ACT_ROUND_EN: segment shifts round half-up instead of flooring.
module sigmoid_plan_core
  import act_pkg::*;
#(
  parameter int MAG_W      = 16,
  parameter int FRAC_WIDTH = 8,
  parameter int S_W        = FRAC_WIDTH + 2
) (
  input  logic [MAG_W-1:0] i_a,
  output logic [S_W-1:0]   o_s
);

  localparam logic [MAG_W-1:0] C_ONE =
    MAG_W'(bp_one(FRAC_WIDTH));
  localparam logic [MAG_W-1:0] C_MID =
    MAG_W'(bp_mid(FRAC_WIDTH));
  localparam logic [MAG_W-1:0] C_SAT =
    MAG_W'(bp_sat(FRAC_WIDTH));

  localparam logic [S_W-1:0] C_R0 =
    S_W'(off_r0(FRAC_WIDTH));
  localparam logic [S_W-1:0] C_R1 =
    S_W'(off_r1(FRAC_WIDTH));
  localparam logic [S_W-1:0] C_R2 =
    S_W'(off_r2(FRAC_WIDTH));
  localparam logic [S_W-1:0] C_S1 =
    S_W'(bp_one(FRAC_WIDTH));

  function automatic logic [MAG_W-1:0] shr(
    input logic [MAG_W-1:0] v,
    input int               k
  );
    logic [MAG_W:0] t;
`ifdef ACT_ROUND_EN
    t = {1'b0, v} + ((MAG_W+1)'(1) << (k - 1));
`else
    t = {1'b0, v};
`endif
    return MAG_W'(t >> k);
  endfunction

  logic [S_W-1:0] w_seg0;
  logic [S_W-1:0] w_seg1;
  logic [S_W-1:0] w_seg2;

  // Selected segments stay below 1.0, so narrowing the shift is safe
  assign w_seg0 = S_W'(shr(i_a, SH_R0)) + C_R0;
  assign w_seg1 = S_W'(shr(i_a, SH_R1)) + C_R1;
  assign w_seg2 = S_W'(shr(i_a, SH_R2)) + C_R2;

  // Pick the segment that covers the magnitude
  always_comb begin
    o_s = '0;
    unique case (1'b1)
      (i_a >= C_SAT):                  o_s = C_S1;
      (i_a >= C_MID) && (i_a < C_SAT): o_s = w_seg2;
      (i_a >= C_ONE) && (i_a < C_MID): o_s = w_seg1;
      (i_a <  C_ONE):                  o_s = w_seg0;
      default:                         o_s = '0;
    endcase
  end

endmodule

// File: rtl/sigmoid_tanh.sv
// Two-stage pipelined sigmoid / tanh (tanh = 2*sigmoid(2x) - 1).
// Macro ACT_ROUND_EN selects round-half-up shifts in the PLAN core.
module sigmoid_tanh
  import act_pkg::*;
#(
  parameter int INT_WIDTH  = 8,
  parameter int FRAC_WIDTH = 8,
  parameter int IS_TANH    = 0,
  parameter int WIDTH      = INT_WIDTH + FRAC_WIDTH + 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic signed [WIDTH-1:0] x,
  output logic signed [WIDTH-1:0] y
);

  localparam int MAG_W = WIDTH - 1;
  localparam int S_W   = FRAC_WIDTH + 2;

  localparam logic [S_W-1:0] C_ONE_S =
    S_W'(bp_one(FRAC_WIDTH));
  localparam logic signed [WIDTH-1:0] C_ONE_W =
    WIDTH'(bp_one(FRAC_WIDTH));

  logic signed [WIDTH:0] w_z;
  logic                  w_neg;
  logic [WIDTH:0]        w_abs;
  logic                  w_ovf;
  logic [MAG_W-1:0]      w_mag;

  // z is one bit wider so that 2x never wraps
  assign w_z   = (IS_TANH != 0) ? {x, 1'b0}
                                : {x[WIDTH-1], x};
  assign w_neg = w_z[WIDTH];
  assign w_abs = w_neg ? $unsigned(-w_z)
                       : $unsigned(w_z);
  assign w_ovf = |w_abs[WIDTH:MAG_W];
  assign w_mag = w_ovf ? '1 : w_abs[MAG_W-1:0];

  logic             r_neg;
  logic [MAG_W-1:0] r_mag;

  // Stage 1: register sign and saturated magnitude of z
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_neg <= 1'b0;
      r_mag <= '0;
    end else begin
      r_neg <= w_neg;
      r_mag <= w_mag;
    end
  end

  logic [S_W-1:0] w_s;

  sigmoid_plan_core #(
    .MAG_W      (MAG_W),
    .FRAC_WIDTH (FRAC_WIDTH),
    .S_W        (S_W)
  ) u_core (
    .i_a (r_mag),
    .o_s (w_s)
  );

  logic [S_W-1:0]          w_s_sgn;
  logic signed [WIDTH-1:0] w_sv;
  logic signed [WIDTH-1:0] w_y;

  // Mirroring about 0.5 keeps the odd symmetry exact
  assign w_s_sgn = r_neg ? (C_ONE_S - w_s) : w_s;
  assign w_sv    = signed'(WIDTH'(w_s_sgn));
  assign w_y     = (IS_TANH != 0)
                 ? (w_sv <<< 1) - C_ONE_W
                 : w_sv;

  // Stage 2: register the activation result
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      y <= '0;
    end else begin
      y <= w_y;
    end
  end

endmodule

// File: tb/tb_sigmoid_tanh.sv
// Directed and sweep bench for sigmoid_tanh (sigmoid and tanh
// instances side by side, driven by the same input).
module tb_sigmoid_tanh;
  import act_pkg::*;

  logic clk;
  logic reset;
  fix_t x;
  fix_t y_sig;
  fix_t y_tanh;

  int total;
  int bad;

  localparam int NSW = 32768;
  int rs[NSW];
  int rt[NSW];

  sigmoid_tanh #(
    .INT_WIDTH  (8),
    .FRAC_WIDTH (8),
    .IS_TANH    (0)
  ) u_sig (
    .clk   (clk),
    .reset (reset),
    .x     (x),
    .y     (y_sig)
  );

  sigmoid_tanh #(
    .INT_WIDTH  (8),
    .FRAC_WIDTH (8),
    .IS_TANH    (1)
  ) u_tanh (
    .clk   (clk),
    .reset (reset),
    .x     (x),
    .y     (y_tanh)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic settle(input fix_t v);
    x = v;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    x     = '0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (y_sig !== 17'sd0) begin
      bad++;
      $display("FAIL rst_sig got=%0d want=0", y_sig);
    end
    total++;
    if (y_tanh !== 17'sd0) begin
      bad++;
      $display("FAIL rst_tanh got=%0d want=0", y_tanh);
    end
    reset = 1'b0;
    settle(17'sd0);
    total++;
    if (y_sig !== 17'sd128) begin
      bad++;
      $display("FAIL first_sig got=%0d want=128", y_sig);
    end
    total++;
    if (y_tanh !== 17'sd0) begin
      bad++;
      $display("FAIL first_tanh got=%0d want=0", y_tanh);
    end
  endtask

  task automatic test_sigmoid;
    int xs[3] = '{-1024, 1024, 256};
    int ex[3] = '{8, 248, 192};
    for (int i = 0; i < 3; i++) begin
      settle(fix_t'(xs[i]));
      total++;
      if (int'(y_sig) !== ex[i]) begin
        bad++;
        $display("FAIL sig x=%0d got=%0d want=%0d",
                 xs[i], y_sig, ex[i]);
      end
    end
  endtask

  task automatic test_tanh;
    int xs[4] = '{0, 512, -512, 256};
    int ex[4] = '{0, 240, -240, 192};
    for (int i = 0; i < 4; i++) begin
      settle(fix_t'(xs[i]));
      total++;
      if (int'(y_tanh) !== ex[i]) begin
        bad++;
        $display("FAIL tanh x=%0d got=%0d want=%0d",
                 xs[i], y_tanh, ex[i]);
      end
    end
  endtask

  task automatic test_saturation;
    fix_t xs[2] = '{17'h0FFFF, 17'h10000};
    int   es[2] = '{256, 0};
    int   et[2] = '{256, -256};
    for (int i = 0; i < 2; i++) begin
      settle(xs[i]);
      total++;
      if (int'(y_sig) !== es[i]) begin
        bad++;
        $display("FAIL sat_sig x=%h got=%0d want=%0d",
                 xs[i], y_sig, es[i]);
      end
      total++;
      if (int'(y_tanh) !== et[i]) begin
        bad++;
        $display("FAIL sat_tanh x=%h got=%0d want=%0d",
                 xs[i], y_tanh, et[i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    int xs[3] = '{0, 256, 1024};
    int es[3] = '{128, 192, 248};
    int et[3] = '{0, 192, 256};
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      if (k >= 2) begin
        total++;
        if (int'(y_sig) !== es[k-2]) begin
          bad++;
          $display("FAIL b2b_sig i=%0d got=%0d want=%0d",
                   k - 2, y_sig, es[k-2]);
        end
        total++;
        if (int'(y_tanh) !== et[k-2]) begin
          bad++;
          $display("FAIL b2b_tanh i=%0d got=%0d want=%0d",
                   k - 2, y_tanh, et[k-2]);
        end
      end
      if (k < 3) x = fix_t'(xs[k]);
    end
  endtask

  task automatic test_mid_reset;
    x = 17'sd1024;
    @(posedge clk);
    #1;
    x = -17'sd1024;
    #2;
    reset = 1'b1;
    #1;
    total++;
    if (y_sig !== 17'sd0) begin
      bad++;
      $display("FAIL midrst_sig got=%0d want=0", y_sig);
    end
    total++;
    if (y_tanh !== 17'sd0) begin
      bad++;
      $display("FAIL midrst_tanh got=%0d want=0", y_tanh);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if (y_sig !== 17'sd128) begin
      bad++;
      $display("FAIL flush_sig got=%0d want=128", y_sig);
    end
    total++;
    if (y_tanh !== 17'sd0) begin
      bad++;
      $display("FAIL flush_tanh got=%0d want=0", y_tanh);
    end
    @(posedge clk);
    #1;
    total++;
    if (y_sig !== 17'sd8) begin
      bad++;
      $display("FAIL resume_sig got=%0d want=8", y_sig);
    end
    total++;
    if (y_tanh !== -17'sd256) begin
      bad++;
      $display("FAIL resume_tanh got=%0d want=-256", y_tanh);
    end
  endtask

  // Stride-4 sweep of the whole input range, streamed one per clock
  task automatic test_sweep;
    int  n_es, n_et, n_ms, n_mt, n_ss, n_st;
    real xr, id, got, e;
    real lim_s, lim_t;
    n_es = 0; n_et = 0; n_ms = 0;
    n_mt = 0; n_ss = 0; n_st = 0;
    // Segment error plus the floor of the shifted term
    lim_s = 0.02 + 1.0 / 256.0;
    lim_t = 0.04 + 2.0 / 256.0;
    for (int k = 0; k < NSW + 2; k++) begin
      @(posedge clk);
      #1;
      if (k >= 2) begin
        rs[k-2] = int'(y_sig);
        rt[k-2] = int'(y_tanh);
      end
      if (k < NSW) x = fix_t'(-65536 + 4 * k);
    end
    for (int k = 0; k < NSW; k++) begin
      xr  = real'(-65536 + 4 * k) / 256.0;
      id  = 1.0 / (1.0 + $exp(-xr));
      got = real'(rs[k]) / 256.0;
      e   = (got > id) ? got - id : id - got;
      if (e > lim_s) n_es++;
      id  = 2.0 / (1.0 + $exp(-2.0 * xr)) - 1.0;
      got = real'(rt[k]) / 256.0;
      e   = (got > id) ? got - id : id - got;
      if (e > lim_t) n_et++;
      if (k > 0) begin
        if (rs[k] < rs[k-1]) n_ms++;
        if (rt[k] < rt[k-1]) n_mt++;
        if (rs[k] + rs[NSW-k] != 256) n_ss++;
        if (rt[NSW-k] != -rt[k]) n_st++;
      end
    end
    total++;
    if (n_es !== 0) begin
      bad++;
      $display("FAIL sweep_err_sig got=%0d want=0", n_es);
    end
    total++;
    if (n_et !== 0) begin
      bad++;
      $display("FAIL sweep_err_tanh got=%0d want=0", n_et);
    end
    total++;
    if (n_ms !== 0) begin
      bad++;
      $display("FAIL mono_sig got=%0d want=0", n_ms);
    end
    total++;
    if (n_mt !== 0) begin
      bad++;
      $display("FAIL mono_tanh got=%0d want=0", n_mt);
    end
    total++;
    if (n_ss !== 0) begin
      bad++;
      $display("FAIL sym_sig got=%0d want=0", n_ss);
    end
    total++;
    if (n_st !== 0) begin
      bad++;
      $display("FAIL sym_tanh got=%0d want=0", n_st);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    x     = '0;
    test_reset();
    test_sigmoid();
    test_tanh();
    test_saturation();
    test_back_to_back();
    test_mid_reset();
    test_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
